seg7_mux_driver: RTL and testbench

//  Time-multiplexed NUM_DIGITS-digit hex seven-segment display driver; successor to the single-digit decoder.

---
 rtl/seg7_mux_driver.sv | 174 +++++++++++++++++
 tb/tb_seg7_mux_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed hex seven-segment driver: one digit per refresh slot, display copy committed at frame wrap.
// Optional decimal point support is compiled in when SEG7_DP_EN is defined.
module seg7_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_blank_en,
`ifdef SEG7_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp,
`endif
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_upd
);

    localparam int PS_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]            SEG_DARK = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    function automatic logic [6:0] glyph_of(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1110011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    logic [PS_W-1:0]         ps_q, ps_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_upd_q, frame_upd_d;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dp_shadow_q, dp_shadow_d;
    logic [NUM_DIGITS-1:0]   dp_disp_q, dp_disp_d;
    logic                    dp_q, dp_d;
`endif

    logic                    tick;
    logic                    boundary;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_dark;
    logic                    dark;
    logic [6:0]              glyph;

    // Frame wrap is the only point where the displayed word may change.
    always_comb begin
        tick        = (ps_q == PS_W'(REFRESH_DIV - 1));
        boundary    = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
        ps_d        = tick ? '0 : ps_q + 1'b1;
        idx_d       = idx_q;
        if (tick) begin
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end

        shadow_d    = load ? hex_in : shadow_q;
        disp_d      = disp_q;
        pending_d   = pending_q;
        frame_upd_d = 1'b0;
`ifdef SEG7_DP_EN
        dp_shadow_d = load ? dp_in : dp_shadow_q;
        dp_disp_d   = dp_disp_q;
`endif
        if (boundary) begin
            if (load) begin
                disp_d      = hex_in;
`ifdef SEG7_DP_EN
                dp_disp_d   = dp_in;
`endif
                pending_d   = 1'b0;
                frame_upd_d = 1'b1;
            end else if (pending_q) begin
                disp_d      = shadow_q;
`ifdef SEG7_DP_EN
                dp_disp_d   = dp_shadow_q;
`endif
                pending_d   = 1'b0;
                frame_upd_d = 1'b1;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // lz_dark[k]: every digit from the top down to k is zero; digit 0 is never suppressed.
    always_comb begin
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (disp_q[4*k +: 4] == 4'h0);
            lz_dark[k] = zero_run;
        end
    end

    always_comb begin
        dark  = blank_mask[idx_q] || (lz_blank_en && lz_dark[idx_q]);
        glyph = dark ? 7'h00 : glyph_of(disp_q[4*idx_q +: 4]);
        seg_d = ACTIVE_LOW_SEG ? ~glyph : glyph;
        an_d  = NUM_DIGITS'(1) << idx_q;
        if (ACTIVE_LOW_AN) begin
            an_d = ~an_d;
        end
`ifdef SEG7_DP_EN
        dp_d = (dp_disp_q[idx_q] && !blank_mask[idx_q]) ^ ACTIVE_LOW_SEG;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q        <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            disp_q      <= '0;
            pending_q   <= 1'b0;
            seg_q       <= SEG_DARK;
            an_q        <= AN_OFF;
            frame_upd_q <= 1'b0;
`ifdef SEG7_DP_EN
            dp_shadow_q <= '0;
            dp_disp_q   <= '0;
            dp_q        <= ACTIVE_LOW_SEG;
`endif
        end else begin
            ps_q        <= ps_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            frame_upd_q <= frame_upd_d;
`ifdef SEG7_DP_EN
            dp_shadow_q <= dp_shadow_d;
            dp_disp_q   <= dp_disp_d;
            dp_q        <= dp_d;
`endif
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign frame_upd = frame_upd_q;
`ifdef SEG7_DP_EN
    assign dp        = dp_q;
`endif

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Randomized and directed bench for seg7_mux_driver (4 digits, 4 clocks per slot, active-low pins).
module tb_seg7_mux_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  blank_mask = '0;
    logic        lz_blank_en = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_upd;

    int n_checks = 0;
    int n_fails  = 0;

    seg7_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .hex_in(hex_in),
        .blank_mask(blank_mask), .lz_blank_en(lz_blank_en),
        .seg(seg), .an(an), .frame_upd(frame_upd)
    );

    always #5 clk = ~clk;

    // Active-high a..g glyphs, indexed by hex value.
    logic [6:0] glyph_tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Reference state: clock edges since reset release, word on display, latest unshown load.
    int          n;
    logic [15:0] shown;
    logic [15:0] latest;
    bit          has_new;
    bit          lz_cur;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        n       = 0;
        shown   = '0;
        latest  = '0;
        has_new = 1'b0;
    endtask

    // One clock: drive on the falling edge, predict the registered outputs, check 1 time unit after the rising edge.
    task automatic step(input bit ld, input logic [15:0] hv, input logic [3:0] bm, input bit lz);
        int         slot;
        bit         bnd;
        bit         dark;
        logic [3:0] digit;
        logic [6:0] eseg;
        logic [3:0] ean;
        bit         efu;
        @(negedge clk);
        load = ld; hex_in = hv; blank_mask = bm; lz_blank_en = lz;
        @(posedge clk);
        slot  = (n / 4) % 4;
        bnd   = (n % 16) == 15;
        digit = shown[slot*4 +: 4];
        dark  = bm[slot] || (lz && slot != 0 && (shown >> (slot * 4)) == 16'h0);
        eseg  = dark ? 7'h7F : ~glyph_tbl[digit];
        ean   = ~(4'b0001 << slot);
        efu   = bnd && (has_new || ld);
        if (bnd && ld) begin
            shown = hv; latest = hv; has_new = 1'b0;
        end else if (bnd && has_new) begin
            shown = latest; has_new = 1'b0;
        end else if (ld) begin
            latest = hv; has_new = 1'b1;
        end
        n++;
        #1;
        chk("seg", 32'(seg), 32'(eseg));
        chk("an", 32'(an), 32'(ean));
        chk("frame_upd", 32'(frame_upd), 32'(efu));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, 4'h0, lz_cur);
    endtask

    task automatic align(input int phase);
        while ((n % 16) != phase) step(1'b0, 16'h0, 4'h0, lz_cur);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_an"}, 32'(an), 32'hF);
        chk({tag, "_fu"}, 32'(frame_upd), 32'h0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        lz_cur = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        check_reset_outputs("reset_held");
        release_reset();

        // Idle frames: digit 0 on every slot, no frame_upd.
        idle(20);

        // Mid-frame load, shown only after the wrap.
        align(5);
        step(1'b1, 16'h12AF, 4'h0, lz_cur);
        idle(40);

        // Leading-zero blanking.
        lz_cur = 1'b1;
        align(6);
        step(1'b1, 16'h0030, 4'h0, lz_cur);
        idle(40);
        step(1'b1, 16'h0000, 4'h0, lz_cur);
        idle(36);
        lz_cur = 1'b0;

        // Two loads in one frame: last wins, single frame_upd.
        align(3);
        step(1'b1, 16'h1111, 4'h0, lz_cur);
        step(1'b1, 16'h2222, 4'h0, lz_cur);
        idle(40);

        // Load on the boundary cycle itself.
        align(15);
        step(1'b1, 16'h5555, 4'h0, lz_cur);
        idle(20);

        // Blank mask on a fixed value.
        step(1'b1, 16'hBEEF, 4'h0, lz_cur);
        idle(16);
        for (int i = 0; i < 32; i++) step(1'b0, 16'h0, 4'b0101, lz_cur);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if ((i % 64) == 0) lz_cur = 1'($urandom);
            step(($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                 lz_cur);
        end

        // Reset mid-frame with a load still pending.
        lz_cur = 1'b0;
        align(2);
        step(1'b1, 16'h9876, 4'h0, lz_cur);
        step(1'b0, 16'h0, 4'h0, lz_cur);
        #1 rst_n = 1'b0;
        load = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        check_reset_outputs("midreset_held");
        release_reset();
        idle(48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
